fsm_serial_negate: RTL and testbench
====================================

# fsm_serial_negate

Multi-channel, bit-serial two's-complement negator for LSB-first serial words. Each channel runs an independent COPY/INVERT state machine, tracks word framing with a bit counter, and selects per word between pass-through and negation. The block sits between serial sources and downstream serial consumers in the FSM datapath. Outputs are registered.

## Interface
- CHANNELS, 4, number of independent serial lanes (≥1)
- WORD_W, 8, bits per serial word (≥2); counter width $clog2(WORD_W)
- clk  input  1  rising-edge clock
- rst_n  input  1  reset, synchronous, active-low
- in_valid  input  CHANNELS  per-lane bit strobe; lane state advances only when set
- x  input  CHANNELS  serial data bit, LSB first
- in_sof  input  CHANNELS  start-of-word; qualified by in_valid
- mode  input  CHANNELS  0 = pass, 1 = negate; sampled on bit 0 of each word
- z  output  CHANNELS  serial result bit
- out_valid  output  CHANNELS  z valid this cycle
- out_eow  output  CHANNELS  z is the last (MSB) bit of a word
- ovf  output  CHANNELS  negation overflow, present only with FSM_SERIAL_NEG_OVF_EN

## Operation
- Per lane: state ∈ {COPY, INVERT}, bit index idx ∈ [0, WORD_W-1], latched mode_q.
- Bit 0 of a word is a valid beat where idx==0 or in_sof==1. On bit 0: idx restarts, mode_q ← mode, state treated as COPY.
- Negate, COPY: z = x; if x==1 → INVERT for the following bits.
- Negate, INVERT: z = ~x; stays INVERT until end of word.
- Pass: z = x for every bit; state stays COPY.
- Last bit (idx==WORD_W-1): out_eow=1; idx wraps to 0, state → COPY.
- in_sof mid-word: current word is abandoned with no out_eow; the beat is bit 0 of a new word.
- in_valid==0: lane holds idx, state, mode_q; out_valid=0 next cycle. Bubbles may appear anywhere in a word.
- Lanes are fully independent; no cross-lane interaction.
- Zero word under negate yields zero (state never leaves COPY).

## Timing
- Latency 1 cycle: a beat at edge N produces z/out_valid/out_eow valid after edge N+1.
- Throughput: 1 bit per lane per cycle.
- Reset (rst_n low at a rising edge): z=0, out_valid=0, out_eow=0, ovf=0, idx=0, state=COPY, mode_q=0. Reset dominates in_valid. Reset mid-word discards the partial word; the first valid beat after reset is bit 0.
- While out_valid=0: z, out_eow and ovf are 0.
- in_sof together with idx==WORD_W-1: in_sof wins; the beat is bit 0 and no out_eow is produced.

## Configuration
- FSM_SERIAL_NEG_OVF_EN defined: the ovf port exists. ovf pulses together with out_eow when a negate-mode word is the most-negative value (state still COPY at the last bit and x==1, e.g. 0x80 for WORD_W=8). z still outputs the unchanged value, 0x80.
- FSM_SERIAL_NEG_OVF_EN undefined: no ovf port and no detection logic; all other behaviour is identical.

## Test plan
- Lane 0, negate, word 0x06 sent LSB-first as 0,1,1,0,0,0,0,0 → z = 0,1,0,1,1,1,1,1 (0xFA); out_eow on the 8th output; latency 1.
- Pass mode, 0xA5 → z reproduces 0xA5 bit-for-bit; back-to-back words re-sample mode at each bit 0.
- Negate 0x00 → 0x00; negate 0x80 → 0x80 with ovf=1 on the eow beat (macro defined); with the macro undefined, the port is absent.
- Negate 0x06 with in_valid bubbles after bits 1 and 4 → same 0xFA sequence, out_valid gaps mirror the input gaps.
- in_sof asserted at bit 3 of a word → no out_eow for the old word; the new word of 0x01 negates to 0xFF.
- rst_n low mid-word on lane 2 while lane 1 streams → all outputs 0 the next cycle; the next word on lane 2 starts at bit 0 and negates correctly.

Source files
------------

// File: rtl/fsm_serial_negate.sv
// rtl/fsm_serial_negate.sv - multi-lane bit-serial two's-complement negator
//
// Each lane receives LSB-first serial words and, per word, either passes the
// bits through or negates them. Negation uses the classic serial rule: copy
// bits up to and including the first 1, then invert every later bit.
//
// Parameters:
//   CHANNELS  number of independent lanes (>= 1)
//   WORD_W    bits per serial word (>= 2)
//
// Ports (all per-lane vectors are CHANNELS wide, bit g belongs to lane g):
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   bit strobe; a lane only advances on a valid beat
//   x          serial data bit, LSB first
//   in_sof     start-of-word, qualified by in_valid
//   mode       0 = pass, 1 = negate; sampled on bit 0 of each word
//   z          registered result bit (0 when out_valid is 0)
//   out_valid  z carries a result this cycle
//   out_eow    z is the MSB of a completed word
//   ovf        negate-mode word was the most-negative value
//              (port exists only when FSM_SERIAL_NEG_OVF_EN is defined)
//
// Optional feature macro: FSM_SERIAL_NEG_OVF_EN

module fsm_serial_negate #(
    parameter int CHANNELS = 4,
    parameter int WORD_W   = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] in_valid,
    input  logic [CHANNELS-1:0] x,
    input  logic [CHANNELS-1:0] in_sof,
    input  logic [CHANNELS-1:0] mode,
    output logic [CHANNELS-1:0] z,
    output logic [CHANNELS-1:0] out_valid,
    output logic [CHANNELS-1:0] out_eow
`ifdef FSM_SERIAL_NEG_OVF_EN
    ,
    output logic [CHANNELS-1:0] ovf
`endif
);

    localparam int IW = $clog2(WORD_W);
    localparam logic [IW-1:0] LAST_IDX = IW'(WORD_W - 1);

    typedef enum logic {
        COPY   = 1'b0,
        INVERT = 1'b1
    } state_t;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
        state_t        state;
        logic [IW-1:0] idx;
        logic          mode_q;
        logic          z_r;
        logic          valid_r;
        logic          eow_r;

        logic          bit0;
        logic          eff_mode;
        logic [IW-1:0] eff_idx;
        logic          cur_invert;
        logic          invert_now;
        logic          last_bit;

        // A beat is bit 0 either at a natural word boundary or when in_sof
        // forces one; in_sof wins even when idx sits on the last bit, so an
        // abandoned word never reports out_eow. On bit 0 the stored state and
        // mode are ignored in favour of COPY and the fresh mode input.
        always_comb begin
            bit0       = (idx == '0) || in_sof[g];
            eff_mode   = bit0 ? mode[g] : mode_q;
            eff_idx    = bit0 ? '0 : idx;
            cur_invert = !bit0 && (state == INVERT);
            invert_now = eff_mode && cur_invert;
            last_bit   = (eff_idx == LAST_IDX);
        end

`ifdef FSM_SERIAL_NEG_OVF_EN
        logic ovf_r;
`endif

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                state   <= COPY;
                idx     <= '0;
                mode_q  <= 1'b0;
                z_r     <= 1'b0;
                valid_r <= 1'b0;
                eow_r   <= 1'b0;
`ifdef FSM_SERIAL_NEG_OVF_EN
                ovf_r   <= 1'b0;
`endif
            end else if (in_valid[g]) begin
                valid_r <= 1'b1;
                z_r     <= x[g] ^ invert_now;
                eow_r   <= last_bit;
`ifdef FSM_SERIAL_NEG_OVF_EN
                // Still copying at the MSB with a 1 there means every lower
                // bit was 0: the most-negative value, which has no positive
                // counterpart. z still reproduces it unchanged.
                ovf_r   <= last_bit && eff_mode && !cur_invert && x[g];
`endif
                mode_q  <= eff_mode;
                if (last_bit) begin
                    idx   <= '0;
                    state <= COPY;
                end else begin
                    idx   <= eff_idx + 1'b1;
                    // Pass mode never leaves COPY; negate enters INVERT after
                    // the first 1 and stays there for the rest of the word.
                    state <= (cur_invert || (eff_mode && x[g])) ? INVERT : COPY;
                end
            end else begin
                valid_r <= 1'b0;
                z_r     <= 1'b0;
                eow_r   <= 1'b0;
`ifdef FSM_SERIAL_NEG_OVF_EN
                ovf_r   <= 1'b0;
`endif
            end
        end

        assign z[g]         = z_r;
        assign out_valid[g] = valid_r;
        assign out_eow[g]   = eow_r;
`ifdef FSM_SERIAL_NEG_OVF_EN
        assign ovf[g]       = ovf_r;
`endif
    end

endmodule

// File: tb/tb_fsm_serial_negate.sv
// tb/tb_fsm_serial_negate.sv - scoreboard testbench for fsm_serial_negate
module tb_fsm_serial_negate;

    localparam int CH = 4;
    localparam int W  = 8;

`ifdef FSM_SERIAL_NEG_OVF_EN
    localparam logic OVF_ON = 1'b1;
`else
    localparam logic OVF_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [CH-1:0] in_valid = '0;
    logic [CH-1:0] x = '0;
    logic [CH-1:0] in_sof = '0;
    logic [CH-1:0] mode = '0;
    logic [CH-1:0] z;
    logic [CH-1:0] out_valid;
    logic [CH-1:0] out_eow;
    logic [CH-1:0] ovf_w;

    int checks = 0;
    int errors = 0;

    // Per-lane expected beats, packed as {z, out_eow, ovf}.
    logic [2:0] exp_q [CH][$];

    always #5 clk = ~clk;

    fsm_serial_negate #(
        .CHANNELS(CH),
        .WORD_W  (W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .x        (x),
        .in_sof   (in_sof),
        .mode     (mode),
        .z        (z),
        .out_valid(out_valid),
        .out_eow  (out_eow)
`ifdef FSM_SERIAL_NEG_OVF_EN
        ,
        .ovf      (ovf_w)
`endif
    );

`ifndef FSM_SERIAL_NEG_OVF_EN
    assign ovf_w = '0;
`endif

    task automatic chk(input string nm, input logic [CH-1:0] got, input logic [CH-1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %b expected %b", nm, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        in_valid = '0;
        in_sof   = '0;
        x        = '0;
        mode     = '0;
    endtask

    task automatic beat(input int ln, input logic xb, input logic sof, input logic md,
                        input logic ez, input logic eeow, input logic eovf);
        in_valid[ln] = 1'b1;
        x[ln]        = xb;
        in_sof[ln]   = sof;
        mode[ln]     = md;
        exp_q[ln].push_back({ez, eeow, eovf});
    endtask

    // bubbles[i] inserts one idle cycle after bit i.
    task automatic send_word(input int ln, input logic [7:0] win, input logic md,
                             input logic [7:0] wexp, input logic eovf,
                             input logic sof0, input logic [7:0] bubbles);
        for (int i = 0; i < W; i++) begin
            beat(ln, win[i], sof0 && (i == 0), md, wexp[i], i == W - 1, eovf && (i == W - 1));
            tick();
            if (i == 0) chk($sformatf("latency_lane%0d", ln), {3'b0, out_valid[ln]}, 4'b0001);
            if (bubbles[i]) tick();
        end
    endtask

    // Monitor: pops and compares whenever a lane presents out_valid.
    initial begin
        logic [2:0] e;
        forever begin
            @(negedge clk);
            for (int i = 0; i < CH; i++) begin
                if (out_valid[i]) begin
                    checks++;
                    if (exp_q[i].size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_beat lane%0d: got z=%b eow=%b ovf=%b expected no output",
                                 i, z[i], out_eow[i], ovf_w[i]);
                    end else begin
                        e = exp_q[i].pop_front();
                        if ({z[i], out_eow[i], ovf_w[i]} !== e) begin
                            errors++;
                            $display("FAIL beat_lane%0d: got z/eow/ovf=%b%b%b expected %b",
                                     i, z[i], out_eow[i], ovf_w[i], e);
                        end
                    end
                end else begin
                    checks++;
                    if ({z[i], out_eow[i], ovf_w[i]} !== 3'b000) begin
                        errors++;
                        $display("FAIL idle_lane%0d: got z/eow/ovf=%b%b%b expected 000",
                                 i, z[i], out_eow[i], ovf_w[i]);
                    end
                end
            end
        end
    end

    initial begin
        logic [7:0] w;
        logic [7:0] e;
        logic [7:0] a;

        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid", out_valid, '0);
        chk("reset_z", z, '0);
        chk("reset_eow", out_eow, '0);
        chk("reset_ovf", ovf_w, '0);
        rst_n = 1'b1;
        tick();

        // Negate 0x06 -> 0xFA on lane 0.
        send_word(0, 8'h06, 1'b1, 8'hFA, 1'b0, 1'b0, 8'h00);

        // Back-to-back words on lane 1, mode re-sampled at each bit 0.
        send_word(1, 8'hA5, 1'b0, 8'hA5, 1'b0, 1'b0, 8'h00);
        send_word(1, 8'h06, 1'b1, 8'hFA, 1'b0, 1'b0, 8'h00);
        send_word(1, 8'h3C, 1'b0, 8'h3C, 1'b0, 1'b0, 8'h00);

        // Lane 2: zero, most-negative, and 0x01.
        send_word(2, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00);
        send_word(2, 8'h80, 1'b1, 8'h80, OVF_ON, 1'b0, 8'h00);
        send_word(2, 8'h01, 1'b1, 8'hFF, 1'b0, 1'b0, 8'h00);

        // Lane 3: bubbles after bits 1 and 4.
        send_word(3, 8'h06, 1'b1, 8'hFA, 1'b0, 1'b0, 8'b0001_0010);

        // Lane 0: in_sof at bit 3 abandons the word; new word 0x01 -> 0xFF.
        w = 8'h06;
        e = 8'hFA;
        for (int i = 0; i < 3; i++) begin
            beat(0, w[i], 1'b0, 1'b1, e[i], 1'b0, 1'b0);
            tick();
        end
        send_word(0, 8'h01, 1'b1, 8'hFF, 1'b0, 1'b1, 8'h00);

        // Lane 3: in_sof on the would-be last bit wins; 0x7F -> 0x81.
        for (int i = 0; i < W - 1; i++) begin
            beat(3, w[i], 1'b0, 1'b1, e[i], 1'b0, 1'b0);
            tick();
        end
        send_word(3, 8'h7F, 1'b1, 8'h81, 1'b0, 1'b1, 8'h00);

        // Reset mid-word on lane 2 while lane 1 streams.
        a = 8'hA5;
        for (int i = 0; i < 3; i++) begin
            beat(1, a[i], 1'b0, 1'b0, a[i], 1'b0, 1'b0);
            beat(2, w[i], 1'b0, 1'b1, e[i], 1'b0, 1'b0);
            tick();
        end
        in_valid = 4'b0110;
        x        = 4'b0110;
        mode     = 4'b0100;
        rst_n    = 1'b0;
        tick();
        chk("rst_mid_out_valid", out_valid, '0);
        chk("rst_mid_z", z, '0);
        chk("rst_mid_eow", out_eow, '0);
        chk("rst_mid_ovf", ovf_w, '0);
        rst_n = 1'b1;
        send_word(2, 8'h06, 1'b1, 8'hFA, 1'b0, 1'b0, 8'h00);
        send_word(1, 8'h06, 1'b1, 8'hFA, 1'b0, 1'b0, 8'h00);

        repeat (3) tick();
        for (int i = 0; i < CH; i++)
            chk($sformatf("drained_lane%0d", i), exp_q[i].size(), '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
